// File: rtl/reset_sequencer.sv
// Staged reset release behind a synchronised, qualified PLL lock; any lock loss re-asserts all stages.
// Optional lock-loss counter enabled by macro RESET_SEQ_LOSS_COUNT_EN (otherwise loss_count is tied to 0).
module reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int NUM_STAGES         = 3,
  parameter int LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      locked,
  output logic [NUM_STAGES-1:0]     sys_reset,
  output logic                      ready,
  output logic [LOSS_CNT_WIDTH-1:0] loss_count
);

  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int GAP_W = $clog2(STAGE_GAP_CYCLES) + 1;
  localparam int STG_W = $clog2(NUM_STAGES + 1);

  localparam logic [STB_W-1:0]      STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [STG_W-1:0]      STG_LAST = STG_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STG_ONE  = NUM_STAGES'(1);

  typedef enum logic [1:0] {S_HOLD, S_STABLE, S_RELEASE, S_RUN} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  state_t                 r_state, w_state_nxt;
  logic [STB_W-1:0]       r_stb_cnt, w_stb_nxt;
  logic [GAP_W-1:0]       r_gap_cnt, w_gap_nxt;
  logic [STG_W-1:0]       r_stage, w_stage_nxt;
  logic [NUM_STAGES-1:0]  r_sys_reset, w_sys_reset_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   w_release;

  // Only this chain samples the asynchronous lock flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_HOLD;
      r_stb_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_stage     <= '0;
      r_sys_reset <= '1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stb_cnt   <= w_stb_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_stage     <= w_stage_nxt;
      r_sys_reset <= w_sys_reset_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stb_nxt       = r_stb_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_stage_nxt     = r_stage;
    w_sys_reset_nxt = r_sys_reset;
    w_ready_nxt     = r_ready;
    w_release       = 1'b0;
    // Lock loss outranks any release or count in the same cycle.
    if (r_state != S_HOLD && !w_locked_s) begin
      w_state_nxt     = S_HOLD;
      w_stb_nxt       = '0;
      w_gap_nxt       = '0;
      w_stage_nxt     = '0;
      w_sys_reset_nxt = '1;
      w_ready_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_sys_reset_nxt = '1;
          w_ready_nxt     = 1'b0;
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
            w_stb_nxt   = '0;
          end
        end
        S_STABLE: begin
          if (r_stb_cnt == STB_LAST) begin
            w_release = 1'b1;
            w_gap_nxt = '0;
            if (NUM_STAGES == 1) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_stb_nxt = r_stb_cnt + STB_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_release = 1'b1;
            w_gap_nxt = '0;
            if (r_stage == STG_LAST) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end
          end else begin
            w_gap_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
        S_RUN: begin
          w_sys_reset_nxt = '0;
          w_ready_nxt     = 1'b1;
        end
        default: w_state_nxt = S_HOLD;
      endcase
      if (w_release) begin
        w_sys_reset_nxt = r_sys_reset & ~(STG_ONE << r_stage);
        w_stage_nxt     = r_stage + STG_W'(1);
      end
    end
  end

  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;

`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_WIDTH-1:0] r_loss_cnt;

  // Only losses out of RUN count; the counter sticks at all ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (r_state == S_RUN && !w_locked_s && r_loss_cnt != '1) begin
      r_loss_cnt <= r_loss_cnt + LOSS_CNT_WIDTH'(1);
    end
  end

  assign loss_count = r_loss_cnt;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: clean lock, unstable lock, RUN loss, glitch, mid-release reset, saturation.
module tb_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       locked;
  logic [2:0] sys_reset;
  logic       ready;
  logic [1:0] loss_count;

  int n_checks;
  int n_fail;
  int n_loss;

  reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .NUM_STAGES        (3),
    .LOSS_CNT_WIDTH    (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .locked    (locked),
    .sys_reset (sys_reset),
    .ready     (ready),
    .loss_count(loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_loss(input int n);
`ifdef RESET_SEQ_LOSS_COUNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  // First posedge of this task is E0 (locked already high before it).
  task automatic run_seq(input string tag);
    logic [31:0] exp_rst;
    logic [31:0] exp_rdy;
    for (int k = 0; k <= 18; k++) begin
      @(posedge clock);
      #1;
      exp_rst = (k < 10) ? 32'h7 : (k < 14) ? 32'h6 : (k < 18) ? 32'h4 : 32'h0;
      exp_rdy = (k >= 18) ? 32'd1 : 32'd0;
      check_eq($sformatf("%s sys_reset E0+%0d", tag, k), 32'(sys_reset), exp_rst);
      check_eq($sformatf("%s ready E0+%0d", tag, k), 32'(ready), exp_rdy);
    end
    check_eq($sformatf("%s loss_count", tag), 32'(loss_count), exp_loss(n_loss));
  endtask

  task automatic start_lock(input string tag);
    @(negedge clock);
    locked = 1'b1;
    run_seq(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset  = 1'b1;
    locked = 1'b0;
    #1;
    check_eq({tag, " rst async sys_reset"}, 32'(sys_reset), 32'h7);
    check_eq({tag, " rst async ready"}, 32'(ready), 32'd0);
    check_eq({tag, " rst async loss"}, 32'(loss_count), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq({tag, " hold sys_reset"}, 32'(sys_reset), 32'h7);
    check_eq({tag, " hold ready"}, 32'(ready), 32'd0);
    n_loss = 0;
  endtask

  // Called from RUN; two edges sample locked=0, the following edge is the new E0.
  task automatic lose_lock(input string tag);
    @(negedge clock);
    locked = 1'b0;
    @(posedge clock);
    #1;
    check_eq({tag, " loss edge1 ready"}, 32'(ready), 32'd1);
    @(posedge clock);
    #1;
    check_eq({tag, " loss edge2 ready"}, 32'(ready), 32'd1);
    @(negedge clock);
    locked = 1'b1;
    n_loss++;
    run_seq(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_loss   = 0;
    reset    = 1'b1;
    locked   = 1'b0;
    #12;
    check_eq("reset sys_reset", 32'(sys_reset), 32'h7);
    check_eq("reset ready", 32'(ready), 32'd0);
    check_eq("reset loss_count", 32'(loss_count), 32'd0);

    // Clean lock
    do_reset("t1");
    start_lock("t1");

    // Unstable lock: drops for edges E0+6..E0+8, relock makes E0+9 the new E0
    do_reset("t2");
    @(negedge clock);
    locked = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("t2 unstable sys_reset E0+%0d", k), 32'(sys_reset), 32'h7);
      check_eq($sformatf("t2 unstable ready E0+%0d", k), 32'(ready), 32'd0);
      if (k == 5) begin
        @(negedge clock);
        locked = 1'b0;
      end
      if (k == 8) begin
        @(negedge clock);
        locked = 1'b1;
      end
    end
    run_seq("t2 relock");

    // Loss in RUN
    lose_lock("t3");

    // Sub-sample glitch in RUN
    for (int g = 0; g < 3; g++) begin
      @(posedge clock);
      #2;
      locked = 1'b0;
      #2;
      locked = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("t6 glitch ready %0d", k), 32'(ready), 32'd1);
      check_eq($sformatf("t6 glitch sys_reset %0d", k), 32'(sys_reset), 32'h0);
    end
    check_eq("t6 glitch loss", 32'(loss_count), exp_loss(n_loss));

    // Mid-release reset at E0+15
    do_reset("t4");
    @(negedge clock);
    locked = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clock);
      #1;
    end
    check_eq("t4 pre-reset sys_reset", 32'(sys_reset), 32'h4);
    reset = 1'b1;
    #1;
    check_eq("t4 async sys_reset", 32'(sys_reset), 32'h7);
    check_eq("t4 async ready", 32'(ready), 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    n_loss = 0;
    run_seq("t4 restart");

    // Saturating loss counter
    for (int i = 1; i <= 5; i++) begin
      lose_lock($sformatf("t5 loss%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
